// File: rtl/bpb_update_ctrl_pkg.sv
// Shared types for the branch-prediction buffer update path.
// Contents: default BPB index width, word type, queued-update record,
// and the sweep/run state encodings used by the update controller.
package bpb_update_ctrl_pkg;

  localparam int BPB_ENTRY_WIDTH0 = 6;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  taken;
  } bpb_update_t;

  localparam logic ST_SWEEP = 1'b0;
  localparam logic ST_RUN   = 1'b1;

endpackage

// File: rtl/bpb_update_fifo.sv
// Dual-enqueue, single-dequeue FIFO of BPB updates.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_clear       synchronous empty (flush)
//   i_enq_valid   per-slot enqueue; slot 0 is written first
//   i_enq_data    per-slot update records
//   i_deq         pop the head this edge
//   o_head        current head record (valid only when o_count != 0)
//   o_count       number of stored entries
// The caller guarantees it never enqueues beyond the free space.
module bpb_update_fifo
  import bpb_update_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic [1:0]           i_enq_valid,
  input  bpb_update_t [1:0]    i_enq_data,
  input  logic                 i_deq,
  output bpb_update_t          o_head,
  output logic [CNT_W-1:0]     o_count
);

  bpb_update_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       w_n_enq;
  logic [PTR_W-1:0] w_wr_ptr1;

  assign w_n_enq   = {1'b0, i_enq_valid[0]} + {1'b0, i_enq_valid[1]};
  // Slot 1 lands right behind slot 0 only when slot 0 is also written.
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(i_enq_valid[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_deq);
      r_count  <= r_count + CNT_W'(w_n_enq) - CNT_W'(i_deq);
    end
  end

  // Storage needs no reset: the head is ignored while the count is zero.
  always_ff @(posedge clk) begin
    if (i_enq_valid[0]) r_mem[r_wr_ptr]  <= i_enq_data[0];
    if (i_enq_valid[1]) r_mem[w_wr_ptr1] <= i_enq_data[1];
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bpb_update_ctrl.sv
// BPB update controller: queues up to two branch-commit updates per cycle
// and drains them one per cycle onto the shared line write path. After
// reset or a flush it sweeps every line clear with prediction held off.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   stall                blocks the dequeue only
//   flush_req            pulse: restart the clearing sweep
//   commit_valid/pc/taken two commit slots, slot 0 program-older
//                        (commit_pc[31:0] is slot 0, [63:32] slot 1)
//   line_wen, line_clr   one-hot write / clear to the BPB lines
//   pc_commit, taken_commit  update currently presented
//   pred_enable          lookups valid
//   busy                 sweeping or queue non-empty
//   drop                 at least one commit discarded this cycle
module bpb_update_ctrl
  import bpb_update_ctrl_pkg::*;
#(
  parameter int ENTRY_WIDTH = BPB_ENTRY_WIDTH0,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush_req,
  input  logic [1:0]                    commit_valid,
  input  logic [63:0]                   commit_pc,
  input  logic [1:0]                    commit_taken,
  output logic [(1<<ENTRY_WIDTH)-1:0]   line_wen,
  output logic [(1<<ENTRY_WIDTH)-1:0]   line_clr,
  output logic [31:0]                   pc_commit,
  output logic                          taken_commit,
  output logic                          pred_enable,
  output logic                          busy,
  output logic                          drop
);

  localparam int NUM_LINES = 1 << ENTRY_WIDTH;
  localparam int CNT_W     = $clog2(QUEUE_DEPTH) + 1;

  logic                   r_state;
  logic [ENTRY_WIDTH-1:0] r_sweep_idx;

  bpb_update_t            w_head;
  bpb_update_t [1:0]      w_enq_data;
  logic [CNT_W-1:0]       w_count;
  logic                   w_run;
  logic                   w_has_head;
  logic                   w_deq;
  logic                   w_can_enq;
  logic [CNT_W:0]         w_free;
  logic [CNT_W:0]         w_need1;
  logic [1:0]             w_acc;
  logic [ENTRY_WIDTH-1:0] w_head_line;

  assign w_run      = (r_state == ST_RUN);
  assign w_has_head = (w_count != '0);
  assign w_deq      = w_run && w_has_head && !stall;

  // A slot freed by this cycle's dequeue is reusable in the same cycle.
  assign w_free    = (CNT_W+1)'(QUEUE_DEPTH) - {1'b0, w_count} + (CNT_W+1)'(w_deq);
  assign w_can_enq = w_run && !flush_req;
  // Slot 1 needs a second free entry only if slot 0 is also enqueuing.
  assign w_need1   = commit_valid[0] ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
  assign w_acc[0]  = w_can_enq && commit_valid[0] && (w_free >= (CNT_W+1)'(1));
  assign w_acc[1]  = w_can_enq && commit_valid[1] && (w_free >= w_need1);

  assign w_enq_data[0] = '{pc: commit_pc[31:0],  taken: commit_taken[0]};
  assign w_enq_data[1] = '{pc: commit_pc[63:32], taken: commit_taken[1]};

  bpb_update_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_clear     (flush_req),
    .i_enq_valid (w_acc),
    .i_enq_data  (w_enq_data),
    .i_deq       (w_deq),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else if (flush_req) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else if (!w_run) begin
      r_sweep_idx <= r_sweep_idx + 1'b1;
      if (r_sweep_idx == {ENTRY_WIDTH{1'b1}}) r_state <= ST_RUN;
    end
  end

  assign w_head_line = w_head.pc[ENTRY_WIDTH+1:2];

  assign line_wen     = w_deq ? (NUM_LINES'(1) << w_head_line) : '0;
  // Gated by reset so the clear and drop strobes read idle while reset is held.
  assign line_clr     = (!w_run && !reset) ? (NUM_LINES'(1) << r_sweep_idx) : '0;
  assign drop         = !reset && |(commit_valid & ~w_acc);
  assign pc_commit    = (w_run && w_has_head) ? w_head.pc : 32'd0;
  assign taken_commit = w_run && w_has_head && w_head.taken;
  assign pred_enable  = w_run;
  assign busy         = !w_run || w_has_head;

endmodule
